// File: rtl/noekeon_core_pkg.sv
// Shared NOEKEON definitions: FSM states, round-constant parameters and
// the word-level helpers (rotations, Pi1/Pi2, Gamma, round-constant steps).
package noekeon_core_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] RC_ENC_INIT = 8'h80;
  localparam logic [7:0] RC_DEC_INIT = 8'hD4;
  localparam logic [7:0] RC_POLY     = 8'h1B;
  localparam int         NUM_ROUNDS  = 16;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {rotl32(s[127:96], 2), rotl32(s[95:64], 5), rotl32(s[63:32], 1), s[31:0]};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {rotr32(s[127:96], 2), rotr32(s[95:64], 5), rotr32(s[63:32], 1), s[31:0]};
  endfunction

  // Nonlinear layer; the a0/a3 swap sits between the two AND/NOR halves.
  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = s[31:0];
    a1 = s[63:32];
    a2 = s[95:64];
    a3 = s[127:96];
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] rc_next_enc(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] rc_next_dec(input logic [7:0] rc);
    return rc[0] ? (((rc ^ RC_POLY) >> 1) | 8'h80) : (rc >> 1);
  endfunction

endpackage

// File: rtl/noekeon_core_theta.sv
// NOEKEON Theta: linear diffusion around a full-width key addition.
module noekeon_core_theta
  import noekeon_core_pkg::*;
#(
  parameter int BLOCK_SIZE = 128
) (
  input  logic [BLOCK_SIZE-1:0] k,
  input  logic [BLOCK_SIZE-1:0] a,
  output logic [BLOCK_SIZE-1:0] y
);

  logic [31:0] w0, w1, w2, w3, t0, t1;

  always_comb begin
    w0 = a[31:0];
    w1 = a[63:32];
    w2 = a[95:64];
    w3 = a[127:96];
    t0 = w0 ^ w2;
    t0 = t0 ^ rotr32(t0, 8) ^ rotl32(t0, 8);
    w1 = w1 ^ t0 ^ k[63:32];
    w3 = w3 ^ t0 ^ k[127:96];
    w0 = w0 ^ k[31:0];
    w2 = w2 ^ k[95:64];
    t1 = w1 ^ w3;
    t1 = t1 ^ rotr32(t1, 8) ^ rotl32(t1, 8);
    w0 = w0 ^ t1;
    w2 = w2 ^ t1;
    y  = {w3, w2, w1, w0};
  end

endmodule

// File: rtl/noekeon_core.sv
// Iterative NOEKEON direct-key cipher: one round per clock, 16 rounds plus a
// final Theta step, with valid/ready handshakes on both sides.
module noekeon_core
  import noekeon_core_pkg::*;
#(
  parameter int KEY_SIZE   = 128,
  parameter int BLOCK_SIZE = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [KEY_SIZE-1:0]   k_in,
  input  logic [BLOCK_SIZE-1:0] a_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] a_out
);

  state_t                state;
  logic                  dec;
  logic [4:0]            rnd;
  logic [7:0]            rc;
  logic [KEY_SIZE-1:0]   wk;
  logic [BLOCK_SIZE-1:0] st;

  logic [BLOCK_SIZE-1:0] rc_word, th_k, th_a, th_y, post, round_out;

  assign rc_word = {{(BLOCK_SIZE-8){1'b0}}, rc};

  // The single Theta instance doubles as the decrypt key schedule while idle.
  always_comb begin
    th_k = wk;
    th_a = dec ? st : (st ^ rc_word);
    if (state == IDLE) begin
      th_k = '0;
      th_a = k_in;
    end
    post      = dec ? (th_y ^ rc_word) : th_y;
    round_out = pi2(gamma(pi1(post)));
  end

  noekeon_core_theta #(.BLOCK_SIZE(BLOCK_SIZE)) u_theta (
    .k (th_k),
    .a (th_a),
    .y (th_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_out     <= '0;
      rnd       <= '0;
      rc        <= RC_ENC_INIT;
      wk        <= '0;
      st        <= '0;
      dec       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= a_in;
            dec      <= mode;
            wk       <= mode ? th_y : k_in;
            rc       <= mode ? RC_DEC_INIT : RC_ENC_INIT;
            rnd      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // rnd == NUM_ROUNDS is the closing Theta/constant step with no Gamma.
          if (rnd == 5'(NUM_ROUNDS)) begin
            a_out     <= post;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st  <= round_out;
            rc  <= dec ? rc_next_dec(rc) : rc_next_enc(rc);
            rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noekeon_core.sv
// Bench for noekeon_core: reference-style NOEKEON model with a constant
// table, a cycle-level handshake model, and directed jobs.
module tb_noekeon_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] k_in = '0;
  logic [127:0] a_in = '0;
  logic         in_ready, out_valid;
  logic [127:0] a_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  localparam logic [127:0] V0   = 128'h503d2dfc_24b70148_699e29fa_b1656851;
  localparam logic [127:0] V1   = 128'h1d1349b2_4f26113f_87c7d092_2a78421b;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] KA   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] AA   = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic [7:0] rct [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                           8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

  noekeon_core #(.KEY_SIZE(128), .BLOCK_SIZE(128)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .k_in(k_in), .a_in(a_in), .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] m_theta(input logic [127:0] kk, input logic [127:0] aa);
    logic [31:0] a [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = aa[32*i +: 32];
    t = a[0] ^ a[2];
    t = t ^ rr(t, 8) ^ rl(t, 8);
    a[1] ^= t;
    a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= kk[32*i +: 32];
    t = a[1] ^ a[3];
    t = t ^ rr(t, 8) ^ rl(t, 8);
    a[0] ^= t;
    a[2] ^= t;
    return {a[3], a[2], a[1], a[0]};
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] kk, input logic [127:0] aa,
                                           input logic [7:0] c1, input logic [7:0] c2);
    logic [31:0] a [4];
    logic [31:0] t;
    logic [127:0] s;
    s = m_theta(kk, aa ^ {120'b0, c1}) ^ {120'b0, c2};
    for (int i = 0; i < 4; i++) a[i] = s[32*i +: 32];
    a[1] = rl(a[1], 1); a[2] = rl(a[2], 5); a[3] = rl(a[3], 2);
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    a[1] = rr(a[1], 1); a[2] = rr(a[2], 5); a[3] = rr(a[3], 2);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] kk, input logic [127:0] aa);
    logic [127:0] s;
    s = aa;
    for (int i = 0; i < 16; i++) s = m_round(kk, s, rct[i], 8'h00);
    s = s ^ {120'b0, rct[16]};
    return m_theta(kk, s);
  endfunction

  function automatic logic [127:0] m_dec(input logic [127:0] kk, input logic [127:0] aa);
    logic [127:0] s, kd;
    kd = m_theta('0, kk);
    s  = aa;
    for (int i = 16; i >= 1; i--) s = m_round(kd, s, 8'h00, rct[i]);
    s = m_theta(kd, s);
    return s ^ {120'b0, rct[0]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-level model of the handshake, compared on every falling edge.
  initial begin : monitor
    bit           m_ready, m_valid, armed;
    int           m_cnt;
    logic [127:0] m_res, m_aout;
    m_ready = 1'b1; m_valid = 1'b0; armed = 1'b0; m_cnt = 0;
    m_res = '0; m_aout = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_ready = 1'b1; m_valid = 1'b0; m_cnt = 0; m_aout = '0; armed = 1'b1;
      end else if (m_ready) begin
        if (in_valid) begin
          m_ready = 1'b0;
          m_cnt   = 17;
          m_res   = mode ? m_dec(k_in, a_in) : m_enc(k_in, a_in);
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_aout  = m_res;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
      @(negedge clk);
      if (armed) begin
        chk("in_ready", {127'b0, in_ready}, {127'b0, m_ready});
        chk("out_valid", {127'b0, out_valid}, {127'b0, m_valid});
        if (m_valid) chk("a_out", a_out, m_aout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit md, input logic [127:0] k, input logic [127:0] a);
    in_valid = 1'b1; mode = md; k_in = k; a_in = a;
    tick();
    in_valid = 1'b0; mode = ~md; k_in = ~k; a_in = a ^ AA;
  endtask

  task automatic wait_done(output logic [127:0] res);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'd17);
    res = a_out;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : main
    logic [127:0] res;
    int           rise [$];
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_a_out", a_out, 128'd0);
    tick();
    rst = 1'b0;

    chk("model_enc_zero", m_enc('0, '0), V0);
    chk("model_dec_zero", m_dec('0, V0), '0);
    chk("model_enc_ones", m_enc(ONES, ONES), V1);

    start_job(1'b0, '0, '0);   wait_done(res); chk("enc_zero", res, V0);  release_result();
    start_job(1'b1, '0, V0);   wait_done(res); chk("dec_zero", res, '0);  release_result();
    start_job(1'b0, ONES, ONES); wait_done(res); chk("enc_ones", res, V1); release_result();

    // Result held under backpressure while new requests are offered.
    start_job(1'b0, KA, AA);
    wait_done(res);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; k_in = {4{$urandom}}; a_in = {4{$urandom}}; mode = i[1];
      @(negedge clk);
      chk("hold_a_out", a_out, m_enc(KA, AA));
      chk("hold_valid", {127'b0, out_valid}, 128'd1);
    end
    in_valid = 1'b0;
    release_result();

    // Abort at rnd=7.
    start_job(1'b0, '0, '0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_a_out", a_out, 128'd0);
    tick();
    rst = 1'b0;
    start_job(1'b0, '0, '0); wait_done(res); chk("enc_after_abort", res, V0); release_result();

    // Abort while holding a result in DONE.
    start_job(1'b1, KA, AA);
    wait_done(res);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("done_abort_valid", {127'b0, out_valid}, 128'd0);
    tick();

    // Back-to-back jobs with out_ready tied high and inputs changing every cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      mode = $urandom_range(0, 1);
      k_in = {$urandom, $urandom, $urandom, $urandom};
      a_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (out_valid) rise.push_back(cyc);
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(rise.size()), 128'd4);
    for (int i = 1; i < rise.size(); i++)
      chk("b2b_spacing", 128'(rise[i] - rise[i-1]), 128'd19);
    repeat (25) tick();
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noekeon_core.md
NOEKEON_CORE -- requirements
Module: noekeon_core

Interface
REQ-001 Parameter KEY_SIZE, default 128, is the key width in bits; only 128 is supported.
REQ-002 Parameter BLOCK_SIZE, default 128, is the block width in bits; only 128 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  key, block and mode are presented.
REQ-006 in_ready  output  1  core can accept a new job.
REQ-007 mode  input  1  0 = encrypt, 1 = decrypt (direct-key mode).
REQ-008 k_in  input  KEY_SIZE  cipher key.
REQ-009 a_in  input  BLOCK_SIZE  plaintext or ciphertext block.
REQ-010 out_valid  output  1  a_out holds a finished result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 a_out  output  BLOCK_SIZE  result block.
REQ-013 Word packing for blocks and keys: word i occupies bits [32i+31:32i]; word 0 is the LSB word.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; in_valid=1 captures a_in, mode and the working key, and moves to RUN with rnd=0.
REQ-016 Working key: encrypt uses k_in; decrypt uses theta(k=0, k_in).
REQ-017 Round constant register: encrypt loads 0x80, decrypt loads 0xD4.
REQ-018 Encrypt advance: rc' = (rc<<1) ^ (rc[7] ? 0x1B : 0), truncated to 8 bits.
REQ-019 Decrypt advance: rc' = rc[0] ? (((rc^0x1B)>>1) | 0x80) : (rc>>1).
REQ-020 One round per RUN cycle.
REQ-021 Encrypt round: a0^=rc; theta(wk); Pi1; Gamma; Pi2.
REQ-022 Decrypt round: theta(wk); a0^=rc; Pi1; Gamma; Pi2.
REQ-023 Pi1 = rotl32 of a1 by 1, a2 by 5, a3 by 2; Pi2 = the matching rotr32 by the same amounts.
REQ-024 Gamma follows the NOEKEON definition.
REQ-025 rnd increments each RUN cycle; after rnd=15 the next cycle is the final step, then state goes to DONE.
REQ-026 Final step, encrypt: a0^=rc(=0xD4); theta(wk).
REQ-027 Final step, decrypt: theta(wk); a0^=rc(=0x80).
REQ-028 Latency: out_valid asserts exactly 17 cycles after the accepting edge.
REQ-029 DONE: out_valid=1 and a_out stays stable until out_ready=1.
REQ-030 out_ready=1 in DONE returns the FSM to IDLE; in_ready=0 in that same cycle (no same-cycle reload).
REQ-031 in_ready=0 in RUN and DONE; in_valid is ignored there.
REQ-032 Inputs are sampled only at the accepting edge; later changes to k_in/a_in do not affect the job.
REQ-033 out_ready asserted outside DONE has no effect.

Reset
REQ-034 rst=1 at a clock edge forces IDLE, in_ready=1, out_valid=0, a_out=0, rnd=0, rc=0x80, and clears key and state registers.
REQ-035 rst asserted mid-RUN or in DONE aborts the job with no result emitted.
REQ-036 rst has priority over every handshake.

Structure
REQ-037 Shared package/include holds: ROTL32/ROTR32 functions, Gamma function, RC_ENC_INIT=0x80, RC_DEC_INIT=0xD4, RC_POLY=0x1B, NUM_ROUNDS=16.
REQ-038 Sub-module: the existing theta diffusion block, instantiated for the datapath.
REQ-039 Key theta for decrypt reuses the same theta block with a zero key, muxed at load.

Verification
REQ-040 Encrypt, key=0, block=0 -> a_out words 0..3 = 0xb1656851, 0x699e29fa, 0x24b70148, 0x503d2dfc after 17 cycles.
REQ-041 Decrypt of the REQ-040 result with key=0 -> all-zero block.
REQ-042 Encrypt, key=all-ones, block=all-ones -> words 0x2a78421b, 0x87c7d092, 0x4f26113f, 0x1d1349b2.
REQ-043 Hold out_ready=0 for 10 cycles in DONE -> a_out stable and out_valid=1 throughout; in_valid pulses ignored.
REQ-044 rst asserted at rnd=7 -> next cycle in IDLE, out_valid=0, a_out=0; next job still produces the REQ-040 result.
REQ-045 Back-to-back jobs with out_ready tied 1 -> one result per 19 cycles, each matching its golden model.
